// File: rtl/key_expansion_inv_seq.sv
// key_expansion_inv_seq
// Sequential AES-128 inverse key schedule. It emits round keys 10 down to 0, one
// per valid/ready handshake. Each backward step is derived from the current round
// key, so only one 128-bit key register is held. Words are packed w[i] = [32i+31:32i]
// and byte 0 of each word sits in its LSBs.
//
// Build option KEYEXP_INV_PRECOMPUTE_EN:
//   defined   - key_in is the cipher key; a 10-cycle FWD phase derives round 10 first.
//   undefined - key_in is already the round-10 key; emission starts immediately.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   load request, sampled only in IDLE
//   key_in     in   128-bit key, captured on the accepted start
//   busy       out  high in every state except IDLE
//   round_key  out  current round key, 0 while key_valid is low
//   round_idx  out  round number of round_key (10..0), 0 while key_valid is low
//   key_valid  out  round_key is valid
//   key_ready  in   consumer accepts round_key when key_valid and key_ready are both high
module key_expansion_inv_seq (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         key_valid,
  input  logic         key_ready
);

  localparam int unsigned NR = 10;
  localparam int unsigned KW = 128;
  localparam int unsigned WW = 32;
  localparam int unsigned IW = 4;

  // AES S-box; entry 0 is the most significant byte, so entry b lives at index ~b.
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [WW-1:0] sub_word(input logic [WW-1:0] w);
    return {SBOX[~w[31:24]], SBOX[~w[23:16]], SBOX[~w[15:8]], SBOX[~w[7:0]]};
  endfunction

  function automatic logic [7:0] rcon(input logic [IW-1:0] i);
    case (i)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

`ifdef KEYEXP_INV_PRECOMPUTE_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FWD = 2'd1, S_EMIT = 2'd2} state_t;
  logic [IW-1:0] cnt_q;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EMIT = 2'd2} state_t;
`endif

  state_t        state_q;
  logic [KW-1:0] key_q;
  logic [IW-1:0] idx_q;

  // Current round key split into words, and the words of the previous round.
  logic [WW-1:0] n0, n1, n2, n3;
  logic [WW-1:0] p1, p2, p3;
  logic [WW-1:0] sw_src, sw_out, t_word;
  logic [IW-1:0] rcon_sel;
  logic [KW-1:0] key_inv_d;

  assign {n3, n2, n1, n0} = key_q;
  assign p3 = n3 ^ n2;
  assign p2 = n2 ^ n1;
  assign p1 = n1 ^ n0;

`ifdef KEYEXP_INV_PRECOMPUTE_EN
  logic [WW-1:0] f0, f1, f2, f3;
  logic [KW-1:0] key_fwd_d;

  // The single SubWord instance is shared: forward step rotates w3, inverse rotates p3.
  assign sw_src   = (state_q == S_FWD) ? n3 : p3;
  assign rcon_sel = (state_q == S_FWD) ? cnt_q : idx_q - IW'(1);

  assign f0        = n0 ^ t_word;
  assign f1        = n1 ^ f0;
  assign f2        = n2 ^ f1;
  assign f3        = n3 ^ f2;
  assign key_fwd_d = {f3, f2, f1, f0};
`else
  assign sw_src   = p3;
  assign rcon_sel = idx_q - IW'(1);
`endif

  assign sw_out    = sub_word({sw_src[7:0], sw_src[31:8]});
  assign t_word    = sw_out ^ {24'h0, rcon(rcon_sel)};
  assign key_inv_d = {p3, p2, p1, n0 ^ t_word};

  // Control FSM; outputs are registered alongside the state that they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      key_q     <= '0;
      idx_q     <= '0;
`ifdef KEYEXP_INV_PRECOMPUTE_EN
      cnt_q     <= '0;
`endif
      busy      <= 1'b0;
      key_valid <= 1'b0;
      round_key <= '0;
      round_idx <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            key_q <= key_in;
            busy  <= 1'b1;
`ifdef KEYEXP_INV_PRECOMPUTE_EN
            cnt_q   <= '0;
            state_q <= S_FWD;
`else
            idx_q     <= IW'(NR);
            state_q   <= S_EMIT;
            key_valid <= 1'b1;
            round_key <= key_in;
            round_idx <= IW'(NR);
`endif
          end
        end
`ifdef KEYEXP_INV_PRECOMPUTE_EN
        S_FWD: begin
          key_q <= key_fwd_d;
          cnt_q <= cnt_q + IW'(1);
          if (cnt_q == IW'(NR - 1)) begin
            idx_q     <= IW'(NR);
            state_q   <= S_EMIT;
            key_valid <= 1'b1;
            round_key <= key_fwd_d;
            round_idx <= IW'(NR);
          end
        end
`endif
        S_EMIT: begin
          if (key_ready) begin
            if (idx_q == '0) begin
              state_q   <= S_IDLE;
              busy      <= 1'b0;
              key_valid <= 1'b0;
              round_key <= '0;
              round_idx <= '0;
            end else begin
              key_q     <= key_inv_d;
              idx_q     <= idx_q - IW'(1);
              round_key <= key_inv_d;
              round_idx <= idx_q - IW'(1);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_expansion_inv_seq.sv
// Testbench for key_expansion_inv_seq: randomized keys and handshake patterns checked
// against a FIPS-197 forward key expansion built from a GF(2^8)-derived S-box.
module tb_key_expansion_inv_seq;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] key_in = '0;
  logic         key_ready = 1'b0;
  logic         busy;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         key_valid;

  key_expansion_inv_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key_in    (key_in),
    .busy      (busy),
    .round_key (round_key),
    .round_idx (round_idx),
    .key_valid (key_valid),
    .key_ready (key_ready)
  );

  always #5 clk = ~clk;

`ifdef KEYEXP_INV_PRECOMPUTE_EN
  localparam int LAT = 10;
`else
  localparam int LAT = 0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]   sb [256];
  logic [127:0] rk [11];
  logic [127:0] obs_key [11];
  logic [3:0]   obs_idx [11];
  int obs_n, first_valid, first_hs, last_hs, hold_err, zero_err, busy_err;
  logic busy0, end_busy, end_valid;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] b);
    return {b[6:0], b[7]};
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv, r1, r2, r3, r4;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      r1 = rotl1(inv); r2 = rotl1(r1); r3 = rotl1(r2); r4 = rotl1(r3);
      sb[a] = inv ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
    end
  endtask

  // Standard byte-oriented forward expansion; fills rk[0..10].
  task automatic expand(input logic [127:0] cipher);
    logic [7:0] w [44][4];
    logic [7:0] tmp [4];
    logic [7:0] rc, b0;
    rc = 8'h01;
    for (int j = 0; j < 16; j++) w[j / 4][j % 4] = cipher[8 * j +: 8];
    for (int i = 4; i < 44; i++) begin
      for (int k = 0; k < 4; k++) tmp[k] = w[i - 1][k];
      if (i % 4 == 0) begin
        b0     = tmp[0];
        tmp[0] = sb[tmp[1]] ^ rc;
        tmp[1] = sb[tmp[2]];
        tmp[2] = sb[tmp[3]];
        tmp[3] = sb[b0];
        rc     = xtime(rc);
      end
      for (int k = 0; k < 4; k++) w[i][k] = w[i - 4][k] ^ tmp[k];
    end
    for (int r = 0; r < 11; r++)
      for (int c = 0; c < 4; c++)
        for (int k = 0; k < 4; k++)
          rk[r][8 * (4 * c + k) +: 8] = w[4 * r + c][k];
  endtask

  // FIPS-197 hex strings list byte 0 first; the DUT packs byte 0 at [7:0].
  function automatic logic [127:0] from_fips(input logic [127:0] f);
    logic [127:0] o;
    for (int j = 0; j < 16; j++) o[8 * j +: 8] = f[127 - 8 * j -: 8];
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] drive_key(input logic [127:0] cipher);
`ifdef KEYEXP_INV_PRECOMPUTE_EN
    return cipher;
`else
    return rk[10];
`endif
  endfunction

  // Starts one sequence and records every handshake.
  // rmode: 0 ready high, 1 ready pattern 1,0,0 repeating, 2 random ready.
  // smode: 1 pulses start during the run, including on the round-0 handshake.
  task automatic run_seq(input logic [127:0] kin, input int rmode, input int smode);
    int cyc, rcnt;
    logic r, prev_hold;
    logic [127:0] pk;
    logic [3:0] pi;
    obs_n = 0; first_valid = -1; first_hs = -1; last_hs = -1;
    hold_err = 0; zero_err = 0; busy_err = 0;
    prev_hold = 1'b0; pk = '0; pi = '0; cyc = 0; rcnt = 0; r = 1'b0;
    key_in = kin; start = 1'b1; key_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; key_in = rand128(); busy0 = busy;
    while (obs_n < 11 && cyc < 400) begin
      if (prev_hold && (round_key !== pk || round_idx !== pi)) hold_err++;
      if (!key_valid && (round_key !== '0 || round_idx !== '0)) zero_err++;
      if (busy !== 1'b1) busy_err++;
      if (key_valid && first_valid < 0) first_valid = cyc;
      case (rmode)
        0:       r = 1'b1;
        1:       r = (rcnt % 3 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      if (key_valid) rcnt++;
      key_ready = r;
      start = (smode != 0) && (cyc == 3 || (key_valid && r && (obs_n == 5 || round_idx == 4'd0)));
      if (key_valid && r) begin
        obs_key[obs_n] = round_key;
        obs_idx[obs_n] = round_idx;
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        obs_n++;
      end
      prev_hold = key_valid && !r;
      pk = round_key; pi = round_idx;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; key_ready = 1'b0;
    end_busy = busy; end_valid = key_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; key_in = rand128();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b expected 0", busy); end
    n_tests++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL reset key_valid: got %b expected 0", key_valid); end
    n_tests++; if (round_key !== '0) begin n_fail++; $display("FAIL reset round_key: got %h expected 0", round_key); end
    n_tests++; if (round_idx !== 4'd0) begin n_fail++; $display("FAIL reset round_idx: got %0d expected 0", round_idx); end
  endtask

  task automatic test_fips_vector();
    logic [127:0] c;
    c = from_fips(128'h2b7e151628aed2a6abf7158809cf4f3c);
    expand(c);
    run_seq(drive_key(c), 0, 0);
    n_tests++; if (obs_n !== 11) begin n_fail++; $display("FAIL fips count: got %0d expected 11", obs_n); end
    n_tests++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL fips busy after start: got %b expected 1", busy0); end
    n_tests++; if (first_valid !== LAT) begin n_fail++; $display("FAIL fips latency: got %0d expected %0d", first_valid, LAT); end
    n_tests++; if (first_hs !== first_valid || last_hs - first_hs !== 10) begin
      n_fail++; $display("FAIL fips consecutive: got span %0d (first %0d) expected 10 (first %0d)", last_hs - first_hs, first_hs, first_valid);
    end
    for (int j = 0; j < 11; j++) begin
      n_tests++;
      if (obs_idx[j] !== 4'(10 - j) || obs_key[j] !== rk[10 - j]) begin
        n_fail++;
        $display("FAIL fips key %0d: got idx %0d key %h expected idx %0d key %h", j, obs_idx[j], obs_key[j], 10 - j, rk[10 - j]);
      end
    end
    n_tests++; if (obs_key[0] !== from_fips(128'hd014f9a8c9ee2589e13f0cc8b6630ca6)) begin
      n_fail++; $display("FAIL fips round10 const: got %h expected %h", obs_key[0], from_fips(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
    end
    n_tests++; if (obs_key[9] !== from_fips(128'ha0fafe1788542cb123a339392a6c7605)) begin
      n_fail++; $display("FAIL fips round1 const: got %h expected %h", obs_key[9], from_fips(128'ha0fafe1788542cb123a339392a6c7605));
    end
    n_tests++; if (obs_key[10] !== c) begin n_fail++; $display("FAIL fips round0 const: got %h expected %h", obs_key[10], c); end
    n_tests++; if (end_busy !== 1'b0 || end_valid !== 1'b0) begin
      n_fail++; $display("FAIL fips end idle: got busy %b valid %b expected 0 0", end_busy, end_valid);
    end
    n_tests++; if (zero_err !== 0 || busy_err !== 0) begin
      n_fail++; $display("FAIL fips invariants: got zero_err %0d busy_err %0d expected 0 0", zero_err, busy_err);
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] c;
    c = rand128();
    expand(c);
    run_seq(drive_key(c), 1, 0);
    n_tests++; if (obs_n !== 11) begin n_fail++; $display("FAIL bp count: got %0d expected 11", obs_n); end
    n_tests++; if (hold_err !== 0) begin n_fail++; $display("FAIL bp hold: got %0d changes expected 0", hold_err); end
    for (int j = 0; j < 11; j++) begin
      n_tests++;
      if (obs_idx[j] !== 4'(10 - j) || obs_key[j] !== rk[10 - j]) begin
        n_fail++;
        $display("FAIL bp key %0d: got idx %0d key %h expected idx %0d key %h", j, obs_idx[j], obs_key[j], 10 - j, rk[10 - j]);
      end
    end
    n_tests++; if (end_busy !== 1'b0) begin n_fail++; $display("FAIL bp end busy: got %b expected 0", end_busy); end
  endtask

  task automatic test_start_ignored();
    logic [127:0] c;
    c = rand128();
    expand(c);
    run_seq(drive_key(c), 2, 1);
    n_tests++; if (obs_n !== 11) begin n_fail++; $display("FAIL start_ign count: got %0d expected 11", obs_n); end
    n_tests++; if (hold_err !== 0) begin n_fail++; $display("FAIL start_ign hold: got %0d changes expected 0", hold_err); end
    for (int j = 0; j < 11; j++) begin
      n_tests++;
      if (obs_idx[j] !== 4'(10 - j) || obs_key[j] !== rk[10 - j]) begin
        n_fail++;
        $display("FAIL start_ign key %0d: got idx %0d key %h expected idx %0d key %h", j, obs_idx[j], obs_key[j], 10 - j, rk[10 - j]);
      end
    end
    n_tests++; if (end_busy !== 1'b0 || end_valid !== 1'b0) begin
      n_fail++; $display("FAIL start_ign end idle: got busy %b valid %b expected 0 0", end_busy, end_valid);
    end
    @(posedge clk); #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL start_ign not queued: got busy %b expected 0", busy); end
    c = rand128();
    expand(c);
    run_seq(drive_key(c), 0, 0);
    n_tests++; if (obs_n !== 11) begin n_fail++; $display("FAIL start_fresh count: got %0d expected 11", obs_n); end
    for (int j = 0; j < 11; j++) begin
      n_tests++;
      if (obs_idx[j] !== 4'(10 - j) || obs_key[j] !== rk[10 - j]) begin
        n_fail++;
        $display("FAIL start_fresh key %0d: got idx %0d key %h expected idx %0d key %h", j, obs_idx[j], obs_key[j], 10 - j, rk[10 - j]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] c;
    int guard;
`ifdef KEYEXP_INV_PRECOMPUTE_EN
    c = rand128();
    expand(c);
    key_in = drive_key(c); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_tests++; if (busy !== 1'b0 || key_valid !== 1'b0 || round_key !== '0 || round_idx !== 4'd0) begin
      n_fail++; $display("FAIL rst_fwd outputs: got busy %b valid %b key %h idx %0d expected all 0", busy, key_valid, round_key, round_idx);
    end
`endif
    c = rand128();
    expand(c);
    key_in = drive_key(c); start = 1'b1; key_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    guard = 0;
    while (!(key_valid && round_idx == 4'd4) && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    n_tests++; if (guard >= 40) begin n_fail++; $display("FAIL rst_emit reach idx4: got timeout after %0d cycles expected idx 4", guard); end
    n_tests++; if (round_key !== rk[4]) begin n_fail++; $display("FAIL rst_emit key4: got %h expected %h", round_key, rk[4]); end
    rst = 1'b1; key_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    n_tests++; if (busy !== 1'b0 || key_valid !== 1'b0 || round_key !== '0 || round_idx !== 4'd0) begin
      n_fail++; $display("FAIL rst_emit outputs: got busy %b valid %b key %h idx %0d expected all 0", busy, key_valid, round_key, round_idx);
    end
    @(posedge clk); #1;
    n_tests++; if (busy !== 1'b0 || key_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_emit idle: got busy %b valid %b expected 0 0", busy, key_valid);
    end
    c = rand128();
    expand(c);
    run_seq(drive_key(c), 0, 0);
    n_tests++; if (obs_n !== 11 || first_valid !== LAT) begin
      n_fail++; $display("FAIL rst_restart: got count %0d latency %0d expected 11 %0d", obs_n, first_valid, LAT);
    end
    for (int j = 0; j < 11; j++) begin
      n_tests++;
      if (obs_idx[j] !== 4'(10 - j) || obs_key[j] !== rk[10 - j]) begin
        n_fail++;
        $display("FAIL rst_restart key %0d: got idx %0d key %h expected idx %0d key %h", j, obs_idx[j], obs_key[j], 10 - j, rk[10 - j]);
      end
    end
  endtask

  task automatic test_zero_key();
    expand('0);
    run_seq(drive_key('0), 0, 0);
    n_tests++; if (obs_key[0] !== from_fips(128'hb4ef5bcb3e92e21123e951cf6f8f188e)) begin
      n_fail++; $display("FAIL zero round10: got %h expected %h", obs_key[0], from_fips(128'hb4ef5bcb3e92e21123e951cf6f8f188e));
    end
    n_tests++; if (obs_n !== 11 || obs_key[10] !== '0 || obs_idx[10] !== 4'd0) begin
      n_fail++; $display("FAIL zero round0: got count %0d key %h idx %0d expected 11 0 0", obs_n, obs_key[10], obs_idx[10]);
    end
    for (int j = 1; j < 10; j++) begin
      n_tests++;
      if (obs_key[j] !== rk[10 - j]) begin
        n_fail++; $display("FAIL zero key %0d: got %h expected %h", j, obs_key[j], rk[10 - j]);
      end
    end
  endtask

  task automatic test_random();
    logic [127:0] c;
    for (int it = 0; it < 4; it++) begin
      c = rand128();
      expand(c);
      run_seq(drive_key(c), 2, 0);
      n_tests++; if (obs_n !== 11 || hold_err !== 0 || zero_err !== 0) begin
        n_fail++; $display("FAIL rand%0d handshake: got count %0d hold_err %0d zero_err %0d expected 11 0 0", it, obs_n, hold_err, zero_err);
      end
      for (int j = 0; j < 11; j++) begin
        n_tests++;
        if (obs_idx[j] !== 4'(10 - j) || obs_key[j] !== rk[10 - j]) begin
          n_fail++;
          $display("FAIL rand%0d key %0d: got idx %0d key %h expected idx %0d key %h", it, j, obs_idx[j], obs_key[j], 10 - j, rk[10 - j]);
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    build_sbox();
    test_reset();
    test_fips_vector();
    test_backpressure();
    test_start_ignored();
    test_reset_mid();
    test_zero_key();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/key_expansion_inv_seq.md
# key_expansion_inv_seq

Sequential AES-128 inverse key schedule for the garbled decryption path. It accepts a 128-bit key and emits round keys 10 down to 0, one per accepted handshake, through a valid/ready interface. Each backward step is computed on the fly from the current round key, so only one 128-bit key register is held. It sits between the key loader and the inverse-round datapath, which consumes round keys in reverse order.

## Interface
- No parameters. NR = 10 is a fixed localparam.
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  load request; sampled only in IDLE.
- key_in  in  128  key source; sampled on the accepted `start`.
- busy  out  1  high in every state except IDLE.
- round_key  out  128  current round key; 0 whenever `key_valid` is low.
- round_idx  out  4  round number of `round_key` (10..0); 0 whenever `key_valid` is low.
- key_valid  out  1  `round_key` is valid.
- key_ready  in  1  consumer accepts `round_key` when this and `key_valid` are both high.

## Operation
- Packing for all 128-bit values:
  - word w[i] = bits [32i+31:32i].
  - Byte 0 of each word is in its LSBs, so FIPS-197 byte 0 = bits [7:0].
- Rcon[0..9] = 01,02,04,08,10,20,40,80,1b,36.
- Forward step with Rcon index c:
  - t = SubWord(RotWord(w3)) with byte 0 of the result XORed with Rcon[c].
  - RotWord = {w3[7:0], w3[31:8]}.
  - n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2.
- Inverse step from round key n at index r to round r-1:
  - p3 = n3^n2, p2 = n2^n1, p1 = n1^n0.
  - p0 = n0 ^ SubWord(RotWord(p3)) with byte 0 XORed with Rcon[r-1].
- One shared SubBytes-based SubWord instance serves both steps. Its input is muxed by state.
- States:
  - IDLE: outputs low.
    - On `start`: key_reg <= key_in.
    - With the macro: cnt <= 0, go to FWD.
    - Without the macro: idx <= 10, go to EMIT.
  - FWD: each cycle key_reg <= fwd(key_reg, cnt) and cnt++.
    - When cnt == 9 at the edge, also set idx <= 10 and go to EMIT.
  - EMIT: `key_valid` = 1, `round_key` = key_reg, `round_idx` = idx.
    - On handshake with idx == 0: go to IDLE.
    - On handshake with idx > 0: key_reg <= inv(key_reg, idx), idx--.
    - With no handshake: all state holds and outputs stay stable.
- `start` outside IDLE is ignored. It is not queued.
- `start` asserted on the same cycle as the final handshake is ignored; the block returns to IDLE first.
- `rst` at any cycle, including mid-FWD or mid-EMIT: the next state is IDLE and key_reg, cnt and idx are cleared. `busy`, `key_valid`, `round_key` and `round_idx` read 0 in the cycle after the reset edge.

## Timing
- Reset values: `busy` 0, `key_valid` 0, `round_key` 0, `round_idx` 0.
- With the macro:
  - `start` accepted at edge E0; FWD occupies E1..E10.
  - `key_valid` rises after E10, i.e. 10 cycles after the first `busy` cycle.
- Without the macro: `key_valid` rises in the cycle right after the `start` edge.
- With `key_ready` held high, 11 keys are emitted in 11 consecutive cycles. `busy` falls the cycle after the round-0 handshake.
- The inverse step is a single-cycle combinational path: key_reg → SubWord → XOR → key_reg. It is not pipelined.

## Configuration
- KEYEXP_INV_PRECOMPUTE_EN
  - Defined: FWD state and cnt are built. `key_in` is the cipher key (round 0), and round 10 is derived internally before emission.
  - Undefined: FWD and cnt are removed. `key_in` must already be the round-10 key, and emission begins directly.
  - The emitted sequence and the EMIT handshake are identical in both builds.

## Test plan
- FIPS-197 cipher key 2b7e151628aed2a6abf7158809cf4f3c (byte 0 at [7:0]), macro defined, `key_ready`=1:
  - round_idx 10 → key d014f9a8c9ee2589e13f0cc8b6630ca6, 10 cycles after `busy` rises.
  - round_idx 1 → a0fafe1788542cb123a339392a6c7605.
  - round_idx 0 → the cipher key.
- Macro undefined, `key_in`=d014f9a8c9ee2589e13f0cc8b6630ca6: the same 11 keys, first one the cycle after `start`.
- `key_ready` toggled 1,0,0,1,… during EMIT:
  - `round_key` and `round_idx` hold while ready is 0.
  - No keys are skipped or repeated; 11 handshakes total.
- `start` pulsed during FWD and during EMIT: ignored, and the sequence is unchanged.
  - `start` on the round-0 handshake cycle is ignored and the block ends in IDLE.
  - A new `start` in IDLE afterwards begins a fresh sequence.
- `rst` asserted mid-FWD (cnt=5) and separately mid-EMIT (round_idx=4): next cycle all outputs are 0 and the block is IDLE. A following `start` yields the full correct sequence.
- All-zero key, macro defined: round-10 key b4ef5bcb3e92e21123e951cf6f8f188e. Reverse steps return to 0 at round_idx 0.
